// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with one-hot grant, hold limit and timeout pulse
module rr_grant_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           done,
  output logic [N-1:0]           grant,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   grant_valid,
  output logic                   timeout
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] ptr, win_hi, win_lo, win, nxt;
  logic [CW-1:0] hold_cnt;
  logic any_hi, release_now;
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    any_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      win_lo = req[i] ? IW'(i) : win_lo;
      win_hi = (req[i] && i >= int'(ptr)) ? IW'(i) : win_hi;
      any_hi = (req[i] && i >= int'(ptr)) ? 1'b1 : any_hi;
    end
  end
  assign win = any_hi ? win_hi : win_lo;
  assign nxt = (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
  assign release_now = done[grant_id] || !req[grant_id] || hold_cnt == CW'(MAX_HOLD - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grant <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          grant <= {{(N-1){1'b0}}, 1'b1} << win;
          grant_id <= win;
          grant_valid <= 1'b1;
          hold_cnt <= '0;
          state <= GRANT;
        end
        GRANT: if (release_now) begin
          grant <= '0;
          grant_valid <= 1'b0;
          ptr <= nxt;
          timeout <= req[grant_id] && !done[grant_id];
          state <= IDLE;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed checks of rotation, release, timeout and reset behaviour
module tb_rr_grant_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, done, grant;
  logic [1:0] grant_id;
  logic grant_valid, timeout;
  int checks = 0;
  int failures = 0;
  rr_grant_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] eg, input logic ev, input logic et);
    checks++;
    assert (grant === eg) else begin
      failures++;
      $error("FAIL %s grant observed=%b expected=%b", tag, grant, eg);
    end
    checks++;
    assert (grant_valid === ev) else begin
      failures++;
      $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, ev);
    end
    checks++;
    assert (timeout === et) else begin
      failures++;
      $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, et);
    end
  endtask
  task automatic chk_id(input string tag, input logic [1:0] ei);
    checks++;
    assert (grant_id === ei) else begin
      failures++;
      $error("FAIL %s grant_id observed=%0d expected=%0d", tag, grant_id, ei);
    end
  endtask
  initial begin
    logic [3:0] one;
    rst = 1'b1;
    req = 4'b1111;
    done = 4'b0000;
    tick(2);
    chk("reset", 4'b0000, 1'b0, 1'b0);
    chk_id("reset", 2'd0);
    rst = 1'b0;
    tick(1);
    chk("first_grant", 4'b0001, 1'b1, 1'b0);
    chk_id("first_grant", 2'd0);
    for (int r = 0; r < 5; r++) begin
      one = 4'b0001 << (r % 4);
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("rot%0d_c%0d", r, c), one, 1'b1, 1'b0);
        if (c < 7) tick(1);
      end
      chk_id($sformatf("rot%0d_id", r), 2'(r % 4));
      tick(1);
      chk($sformatf("rot%0d_gap", r), 4'b0000, 1'b0, 1'b1);
      tick(1);
    end
    chk("rot_after", 4'b0010, 1'b1, 1'b0);
    req = 4'b1001;
    tick(1);
    chk("withdraw", 4'b0000, 1'b0, 1'b0);
    tick(1);
    chk("skip", 4'b1000, 1'b1, 1'b0);
    chk_id("skip", 2'd3);
    done = 4'b1000;
    tick(1);
    done = 4'b0000;
    chk("done3_release", 4'b0000, 1'b0, 1'b0);
    tick(1);
    chk("wrap_to0", 4'b0001, 1'b1, 1'b0);
    done = 4'b1000;
    tick(1);
    done = 4'b0000;
    chk("ignored_done", 4'b0001, 1'b1, 1'b0);
    tick(6);
    chk("hold_cnt7", 4'b0001, 1'b1, 1'b0);
    done = 4'b0001;
    tick(1);
    done = 4'b0000;
    chk("done_at_limit", 4'b0000, 1'b0, 1'b0);
    tick(1);
    chk("after_limit", 4'b1000, 1'b1, 1'b0);
    req = 4'b0100;
    tick(1);
    chk("drop3", 4'b0000, 1'b0, 1'b0);
    tick(1);
    chk("single_c0", 4'b0100, 1'b1, 1'b0);
    chk_id("single", 2'd2);
    tick(1);
    chk("single_c1", 4'b0100, 1'b1, 1'b0);
    tick(1);
    chk("single_c2", 4'b0100, 1'b1, 1'b0);
    done = 4'b0100;
    tick(1);
    done = 4'b0000;
    req = 4'b1111;
    chk("single_rel", 4'b0000, 1'b0, 1'b0);
    tick(1);
    chk("ptr3", 4'b1000, 1'b1, 1'b0);
    chk_id("ptr3", 2'd3);
    req = 4'b0100;
    tick(2);
    chk("owner2", 4'b0100, 1'b1, 1'b0);
    rst = 1'b1;
    req = 4'b1100;
    tick(1);
    rst = 1'b0;
    chk("mid_reset", 4'b0000, 1'b0, 1'b0);
    tick(1);
    chk("post_reset", 4'b0100, 1'b1, 1'b0);
    chk_id("post_reset", 2'd2);
    req = 4'b0000;
    tick(2);
    chk("idle_noreq", 4'b0000, 1'b0, 1'b0);
    done = 4'b1111;
    tick(1);
    chk("idle_done", 4'b0000, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
